ssd_scan_ctrl: RTL and testbench

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

---
 rtl/ssd_scan_ctrl.sv | 107 ++++++++++
 tb/tb_ssd_scan_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Scan controller for the stereo disparity engine: walks (row, col, disp) across one
// frame with a VSYNC start-up window and an idle gap ahead of every row.
module ssd_scan_ctrl #(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int MAX_DISP       = 16,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  localparam int ROW_W  = (HEIGHT   > 1) ? $clog2(HEIGHT)   : 1,
  localparam int COL_W  = (WIDTH    > 1) ? $clog2(WIDTH)    : 1,
  localparam int DISP_W = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              stall,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [DISP_W-1:0] disp,
  output logic              pix_valid,
  output logic              disp_first,
  output logic              disp_last,
  output logic              busy,
  output logic              ctrl_done
);

  localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(MAX_DISP - 1);
  // Counter runs down to zero, so a window of N cycles loads N-1 (delays assumed >= 1).
  localparam logic [DLY_W-1:0]  VS_LOAD   = DLY_W'(START_UP_DELAY - 1);
  localparam logic [DLY_W-1:0]  HG_LOAD   = DLY_W'(HSYNC_DELAY - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HGAP, S_DATA, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic             dly_zero, disp_end, col_end, row_end, advance;

  assign dly_zero = (dly_cnt == '0);
  assign disp_end = (disp == DISP_LAST);
  assign col_end  = (col  == COL_LAST);
  assign row_end  = (row  == ROW_LAST);
  assign advance  = (state == S_DATA) && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_VSYNC;
      S_VSYNC: if (dly_zero) state_nxt = S_HGAP;
      S_HGAP:  if (dly_zero) state_nxt = S_DATA;
      S_DATA:  if (advance && disp_end && col_end)
                 state_nxt = row_end ? S_DONE : S_HGAP;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= S_IDLE;
      dly_cnt <= '0;
      row     <= '0;
      col     <= '0;
      disp    <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        case (state_nxt)
          S_VSYNC: dly_cnt <= VS_LOAD;
          S_HGAP:  dly_cnt <= HG_LOAD;
          default: dly_cnt <= '0;
        endcase
      end else if (!dly_zero) begin
        dly_cnt <= dly_cnt - 1'b1;
      end
      // Last tuple of the frame wraps all three indices, so DONE/IDLE see zeros.
      if (advance) begin
        if (disp_end) begin
          disp <= '0;
          if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          disp <= disp + 1'b1;
        end
      end
    end
  end

  assign VSYNC      = (state == S_VSYNC);
  assign pix_valid  = advance;
  assign HSYNC      = advance;
  assign disp_first = advance && (disp == '0);
  assign disp_last  = advance && disp_end;
  assign busy       = (state != S_IDLE);
  assign ctrl_done  = (state == S_DONE);

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: stimulus queues expected events, a negedge
// monitor pops and compares on every VSYNC rise, pix_valid and ctrl_done.
module tb_ssd_scan_ctrl;
  localparam int W = 4, H = 2, D = 2, SUD = 3, HSD = 2;
  localparam int K_VS = 0, K_PIX = 1, K_DONE = 2;

  logic       HCLK = 1'b0, HRESET = 1'b1, start = 1'b0, stall = 1'b0;
  logic       VSYNC, HSYNC, pix_valid, disp_first, disp_last, busy, ctrl_done;
  logic [0:0] row;
  logic [1:0] col;
  logic [0:0] disp;

  ssd_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .MAX_DISP(D), .START_UP_DELAY(SUD),
                  .HSYNC_DELAY(HSD)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .stall(stall),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .row(row), .col(col), .disp(disp),
    .pix_valid(pix_valid), .disp_first(disp_first), .disp_last(disp_last),
    .busy(busy), .ctrl_done(ctrl_done));

  typedef struct {
    int kind;
    int cyc;
    int r, c, d;
    bit first, last;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0, n_fail = 0;
  int  cyc = 0;
  int  pix_cnt = 0, last_cnt = 0;
  bit  prev_vs = 1'b0;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Tuple times follow the frame layout: 1 start cycle, SUD VSYNC cycles, then per
  // row HSD gap cycles and W*D data cycles; a stall window delays everything after it.
  task automatic push_frame(input int base, input int st_at, input int st_len,
                            input int cut, input int done_cyc);
    ev_t e;
    e = '{kind: K_VS, cyc: base + 1, r: 0, c: 0, d: 0, first: 0, last: 0};
    if (e.cyc < cut) exp_q.push_back(e);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int d = 0; d < D; d++) begin
          e.kind = K_PIX;
          e.cyc  = base + 1 + SUD + r * (HSD + W * D) + HSD + c * D + d;
          if (st_len > 0 && e.cyc >= st_at) e.cyc += st_len;
          e.r = r; e.c = c; e.d = d;
          e.first = (d == 0); e.last = (d == D - 1);
          if (e.cyc < cut) exp_q.push_back(e);
        end
    if (done_cyc >= 0) begin
      e = '{kind: K_DONE, cyc: done_cyc, r: 0, c: 0, d: 0, first: 0, last: 0};
      exp_q.push_back(e);
    end
  endtask

  task automatic pop_cmp(input int kind);
    ev_t e;
    bit  bad;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected event kind %0d at cycle %0d (row %0d col %0d disp %0d)",
               kind, cyc, row, col, disp);
      return;
    end
    e = exp_q.pop_front();
    bad = (e.kind != kind) || (e.cyc != cyc) || (busy !== 1'b1);
    if (kind == K_PIX)
      bad |= (row !== e.r[0:0]) || (col !== e.c[1:0]) || (disp !== e.d[0:0]) ||
             (disp_first !== e.first) || (disp_last !== e.last) || (HSYNC !== 1'b1) ||
             (VSYNC !== 1'b0);
    if (kind == K_DONE) bad |= (pix_valid !== 1'b0) || (HSYNC !== 1'b0);
    if (bad) begin
      n_fail++;
      $display("FAIL event: got kind %0d cyc %0d (%0d,%0d,%0d) f%0b l%0b hs%0b busy%0b, expected kind %0d cyc %0d (%0d,%0d,%0d) f%0b l%0b",
               kind, cyc, row, col, disp, disp_first, disp_last, HSYNC, busy,
               e.kind, e.cyc, e.r, e.c, e.d, e.first, e.last);
    end
  endtask

  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (VSYNC && !prev_vs) begin
        pix_cnt = 0; last_cnt = 0;
        pop_cmp(K_VS);
      end
      if (pix_valid) begin
        pix_cnt++;
        if (disp_last) last_cnt++;
        pop_cmp(K_PIX);
      end else if (HSYNC || disp_first || disp_last) begin
        check("strobe_without_valid", {HSYNC, disp_first, disp_last}, 0);
      end
      if (ctrl_done) begin
        pop_cmp(K_DONE);
        check("pix_count", pix_cnt, W * H * D);
        check("disp_last_count", last_cnt, W * H);
      end
    end
    prev_vs = VSYNC;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) tick();
  endtask

  task automatic check_quiet(input string name);
    check(name, {VSYNC, HSYNC, pix_valid, disp_first, disp_last, busy, ctrl_done,
                 row, col, disp}, 0);
  endtask

  task automatic nominal();
    int base;
    base = cyc;
    push_frame(base, 0, 0, 1 << 30, base + 24);
    start = 1'b1; tick(); start = 1'b0;
    drain();
  endtask

  initial begin
    int base;
    #2;
    check_quiet("reset_outputs");
    repeat (2) tick();
    HRESET = 1'b0;
    repeat (3) tick();
    check_quiet("idle_after_release");

    nominal();

    // stall for 3 cycles while presenting (0,1,1)
    base = cyc;
    push_frame(base, base + 9, 3, 1 << 30, base + 27);
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < base + 9) tick();
    stall = 1'b1;
    while (cyc < base + 12) tick();
    stall = 1'b0;
    drain();

    // stall only while in VSYNC / HGAP / DONE: no effect on timing
    base = cyc;
    push_frame(base, 0, 0, 1 << 30, base + 24);
    for (int k = 0; k < 26; k++) begin
      start = (k == 0);
      stall = (k <= 5) || (k == 14) || (k == 15) || (k >= 24);
      tick();
    end
    start = 1'b0; stall = 1'b0;
    drain();

    // start held across the frame: one IDLE cycle, then a second frame
    base = cyc;
    push_frame(base, 0, 0, 1 << 30, base + 24);
    push_frame(base + 25, 0, 0, 1 << 30, base + 25 + 24);
    start = 1'b1;
    while (cyc < base + 25) tick();
    check("idle_between_frames", busy, 0);
    while (cyc < base + 27) tick();
    start = 1'b0;
    drain();

    // asynchronous reset in cycle 10 of a frame
    base = cyc;
    push_frame(base, 0, 0, base + 10, -1);
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < base + 10) tick();
    #1 HRESET = 1'b1;
    #1 check_quiet("async_reset_midframe");
    tick(); tick();
    HRESET = 1'b0;
    check("events_left_after_reset", exp_q.size(), 0);
    repeat (4) tick();
    check_quiet("quiet_after_abort");

    nominal();

    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
